// File: rtl/serv_fetch_if.sv
// Wishbone-classic instruction bus between the fetch stage (master) and memory (slave).
// cyc doubles as stb; adr is always word aligned.
interface serv_fetch_if;
  logic [31:0] adr;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;
  logic        err;

  modport master (output adr, cyc, input  rdt, ack, err);
  modport slave  (input  adr, cyc, output rdt, ack, err);
endinterface

// File: rtl/serv_fetch.sv
// Instruction fetch stage: demand fetch over Wishbone, single-entry PC+4 prefetch buffer,
// bus watchdog and one-cycle delivery/fault/misalign strobes toward the decoder.
module serv_fetch #(
  parameter bit          PREFETCH = 1'b1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_fetch_req,
  input  logic [31:0]  i_pc,
  input  logic         i_flush,
  serv_fetch_if.master ibus,
  output logic [29:0]  o_wb_rdt,
  output logic         o_wb_en,
  output logic         o_fetch_fault,
  output logic         o_misalign,
  output logic         o_busy
);
  localparam int             WDW = $clog2(TIMEOUT + 2);
  localparam logic [WDW-1:0] TMO = WDW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PREF, S_DRAIN} state_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] adr;
    logic [29:0] dat;
  } pbuf_t;

  state_e         state_q;
  pbuf_t          buf_q;
  logic [31:0]    adr_q, pend_pc_q;
  logic           cyc_q, pend_q, busy_q, wb_en_q, fault_q, mis_q;
  logic [29:0]    wb_rdt_q;
  logic [WDW-1:0] wdog_q;

  logic           req_ok, mis, take, ack, err, tmo, ok, bad, close;
  logic           hit, claim, demand, drain, pend_nxt;
  logic [WDW-1:0] wdog_inc;
  logic [31:0]    nxt_pc, drain_pc;
  logic           unused_rdt_lo;

  assign unused_rdt_lo = ^ibus.rdt[1:0];

  always_comb begin
    req_ok   = i_fetch_req & ~busy_q;
    mis      = req_ok & (i_pc[1:0] != 2'b00);
    take     = req_ok & ~mis;
    ack      = cyc_q & ibus.ack;
    err      = cyc_q & ibus.err;
    wdog_inc = wdog_q + 1'b1;
    tmo      = (TIMEOUT != 0) & cyc_q & ~ack & ~err & (wdog_inc == TMO);
    bad      = err | tmo;
    ok       = ack & ~err;
    close    = ok | bad;
    hit      = take & ~i_flush & buf_q.vld & (buf_q.adr == i_pc);
    // A demand for the word already being prefetched adopts the open cycle.
    claim    = (state_q == S_PREF) & cyc_q & take & ~i_flush & (i_pc == adr_q);
    demand   = ((state_q == S_FETCH) & cyc_q) | claim;
    drain    = (state_q == S_DRAIN) |
               ((state_q == S_PREF) & cyc_q & (i_flush | take));
    pend_nxt = ((state_q == S_DRAIN) & pend_q) | take;
    drain_pc = take ? i_pc : pend_pc_q;
    nxt_pc   = adr_q + 32'd4;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      adr_q     <= '0;
      pend_pc_q <= '0;
      pend_q    <= 1'b0;
      cyc_q     <= 1'b0;
      busy_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      fault_q   <= 1'b0;
      mis_q     <= 1'b0;
      wb_rdt_q  <= 30'h0000_0004;
      wdog_q    <= '0;
    end else begin
      wb_en_q <= 1'b0;
      fault_q <= 1'b0;
      mis_q   <= mis;
      if (wb_en_q | fault_q) busy_q <= 1'b0;
      if (i_flush) buf_q.vld <= 1'b0;
      if (cyc_q) wdog_q <= close ? '0 : wdog_inc;

      if (demand) begin
        if (claim) busy_q <= 1'b1;
        if (ok) begin
          wb_en_q  <= 1'b1;
          wb_rdt_q <= ibus.rdt[31:2];
          cyc_q    <= 1'b0;
          if (PREFETCH) begin
            state_q <= S_PREF;
            adr_q   <= nxt_pc;
          end else begin
            state_q <= S_IDLE;
          end
        end else if (bad) begin
          fault_q <= 1'b1;
          cyc_q   <= 1'b0;
          state_q <= S_IDLE;
        end else if (claim) begin
          state_q <= S_FETCH;
        end
      end else if (drain) begin
        if (take) begin
          pend_pc_q <= i_pc;
          busy_q    <= 1'b1;
        end
        if (close) begin
          // Cycle closes with cyc low next clock; a pending demand relaunches after that gap.
          cyc_q  <= 1'b0;
          pend_q <= 1'b0;
          if (pend_nxt) begin
            state_q <= S_FETCH;
            adr_q   <= drain_pc;
          end else begin
            state_q <= S_IDLE;
          end
        end else begin
          state_q <= S_DRAIN;
          pend_q  <= pend_nxt;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (hit) begin
              wb_en_q  <= 1'b1;
              wb_rdt_q <= buf_q.dat;
            end else if (take) begin
              state_q   <= S_FETCH;
              cyc_q     <= 1'b1;
              adr_q     <= i_pc;
              wdog_q    <= '0;
              busy_q    <= 1'b1;
              buf_q.vld <= 1'b0;
            end
          end
          // Only reached with cyc low: the one-cycle gap before a relaunch.
          S_FETCH: begin
            cyc_q  <= 1'b1;
            wdog_q <= '0;
          end
          S_PREF: begin
            if (!cyc_q) begin
              if (i_flush) begin
                state_q <= S_IDLE;
              end else begin
                cyc_q  <= 1'b1;
                wdog_q <= '0;
              end
            end else if (ok) begin
              buf_q   <= '{vld: 1'b1, adr: adr_q, dat: ibus.rdt[31:2]};
              cyc_q   <= 1'b0;
              state_q <= S_IDLE;
            end else if (bad) begin
              cyc_q   <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ibus.adr      = adr_q;
  assign ibus.cyc      = cyc_q;
  assign o_wb_rdt      = wb_rdt_q;
  assign o_wb_en       = wb_en_q;
  assign o_fetch_fault = fault_q;
  assign o_misalign    = mis_q;
  assign o_busy        = busy_q;
endmodule

// File: tb/tb_serv_fetch.sv
// Directed checks of serv_fetch timing followed by a randomized request stream scored
// against a memory model: every request yields exactly one misalign or mem[pc][31:2].
module tb_serv_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] pc;
  logic        flush;
  logic [29:0] wb_rdt;
  logic        wb_en, fault, misal, busy;

  int          nvec = 0;
  int          nerr = 0;
  bit          auto_ack = 1'b0;
  bit          wait_on = 1'b0;
  int          dly = 0;
  logic [31:0] seed;

  serv_fetch_if ibus();

  serv_fetch #(.PREFETCH(1'b1), .TIMEOUT(8)) dut (
    .clk(clk), .i_rst(rst), .i_fetch_req(fetch_req), .i_pc(pc), .i_flush(flush),
    .ibus(ibus), .o_wb_rdt(wb_rdt), .o_wb_en(wb_en), .o_fetch_fault(fault),
    .o_misalign(misal), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge, then play the slave for the coming cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (ibus.cyc) chk("adr_align", 32'(ibus.adr[1:0]), 32'd0);
    if (auto_ack) begin
      ibus.ack = 1'b0;
      if (ibus.cyc) begin
        if (!wait_on) begin
          wait_on = 1'b1;
          dly = int'($urandom_range(0, 3));
        end
        if (dly == 0) begin
          ibus.ack = 1'b1;
          ibus.rdt = mem(ibus.adr);
          wait_on  = 1'b0;
        end else begin
          dly--;
        end
      end else begin
        wait_on = 1'b0;
      end
    end
  endtask

  task automatic req(input logic [31:0] p);
    fetch_req = 1'b1;
    pc        = p;
    step();
    fetch_req = 1'b0;
  endtask

  task automatic ack_step(input logic [31:0] d);
    ibus.ack = 1'b1;
    ibus.rdt = d;
    step();
    ibus.ack = 1'b0;
  endtask

  initial begin
    logic [31:0] rpc, last, ew;
    logic        exp_mis, got, fl;
    int          r;

    seed = $urandom;
    rst = 1'b1; fetch_req = 1'b0; pc = '0; flush = 1'b0;
    ibus.ack = 1'b0; ibus.err = 1'b0; ibus.rdt = '0;

    // Reset state
    step(); step();
    chk("rst_cyc",   32'(ibus.cyc), 32'd0);
    chk("rst_adr",   ibus.adr, 32'd0);
    chk("rst_strb",  32'({wb_en, fault, misal}), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_rdt",   32'(wb_rdt), 32'h4);
    rst = 1'b0;
    step();

    // Demand fetch 0x100, ack after 2 cycles
    req(32'h100);
    chk("f_cyc",  32'(ibus.cyc), 32'd1);
    chk("f_adr",  ibus.adr, 32'h100);
    chk("f_busy", 32'(busy), 32'd1);
    step();
    chk("f_wait", 32'(ibus.cyc), 32'd1);
    ack_step(32'h0050_0093);
    chk("f_en",    32'(wb_en), 32'd1);
    chk("f_rdt",   32'(wb_rdt), 32'h0014_0024);
    chk("f_cyclo", 32'(ibus.cyc), 32'd0);
    chk("f_busy2", 32'(busy), 32'd1);
    step();
    chk("f_en1",   32'(wb_en), 32'd0);
    chk("p_cyc",   32'(ibus.cyc), 32'd1);
    chk("p_adr",   ibus.adr, 32'h104);
    chk("p_busy",  32'(busy), 32'd0);

    // Prefetch completes, then a buffer hit
    ack_step(32'h00A0_0113);
    chk("p_done", 32'(ibus.cyc), 32'd0);
    req(32'h104);
    chk("h_en",  32'(wb_en), 32'd1);
    chk("h_rdt", 32'(wb_rdt), 32'h0028_0044);
    chk("h_cyc", 32'(ibus.cyc), 32'd0);
    step();
    chk("h_nocyc", 32'(ibus.cyc), 32'd0);
    chk("h_en1",   32'(wb_en), 32'd0);

    // Prefetch in flight, jump elsewhere: old data dropped
    req(32'h300);
    ack_step(32'h1111_1110);
    step();
    chk("j_padr", ibus.adr, 32'h304);
    req(32'h200);
    chk("j_busy", 32'(busy), 32'd1);
    chk("j_cyc",  32'(ibus.cyc), 32'd1);
    ack_step(32'hDEAD_BEEF);
    chk("j_drop", 32'({ibus.cyc, wb_en}), 32'd0);
    step();
    chk("j_cyc2", 32'(ibus.cyc), 32'd1);
    chk("j_adr2", ibus.adr, 32'h200);
    ack_step(32'h2222_2220);
    chk("j_en",  32'(wb_en), 32'd1);
    chk("j_rdt", 32'(wb_rdt), 32'h0888_8888);
    step();
    ack_step(32'h0);

    // Bus error on a demand fetch
    req(32'h400);
    ibus.err = 1'b1;
    step();
    ibus.err = 1'b0;
    chk("e_fault", 32'(fault), 32'd1);
    chk("e_en",    32'(wb_en), 32'd0);
    chk("e_cyc",   32'(ibus.cyc), 32'd0);
    chk("e_rdt",   32'(wb_rdt), 32'h0888_8888);
    step();
    chk("e_once",  32'(fault), 32'd0);
    chk("e_nopf",  32'(ibus.cyc), 32'd0);
    chk("e_busy",  32'(busy), 32'd0);

    // Watchdog: cyc stays up exactly 8 cycles
    req(32'h500);
    for (int i = 0; i < 7; i++) step();
    chk("t_cyc8",  32'({ibus.cyc, fault}), 32'b10);
    step();
    chk("t_fault", 32'(fault), 32'd1);
    chk("t_cyc",   32'(ibus.cyc), 32'd0);
    chk("t_rdt",   32'(wb_rdt), 32'h0888_8888);
    step();

    // Misaligned request, then address wrap of the prefetch
    req(32'h102);
    chk("m_pulse", 32'(misal), 32'd1);
    chk("m_cyc",   32'(ibus.cyc), 32'd0);
    step();
    chk("m_once",  32'(misal), 32'd0);
    req(32'hFFFF_FFFC);
    chk("w_adr", ibus.adr, 32'hFFFF_FFFC);
    ack_step(32'h0000_0013);
    step();
    chk("w_wrap", ibus.adr, 32'h0);
    chk("w_cyc",  32'(ibus.cyc), 32'd1);
    ack_step(32'h0);

    // Reset in the middle of a demand cycle
    req(32'h600);
    rst = 1'b1;
    #1;
    chk("r_cyc",  32'(ibus.cyc), 32'd0);
    chk("r_rdt",  32'(wb_rdt), 32'h4);
    chk("r_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    ack_step(32'h5555_5555);
    chk("r_ign", 32'({wb_en, ibus.cyc}), 32'd0);
    chk("r_rdt2", 32'(wb_rdt), 32'h4);

    // Flush together with the prefetch ack: no hit afterwards
    req(32'h700);
    ack_step(32'h7000_0000);
    step();
    flush = 1'b1;
    ack_step(32'h7040_0000);
    flush = 1'b0;
    req(32'h704);
    chk("fl_nohit", 32'(wb_en), 32'd0);
    chk("fl_cyc",   32'(ibus.cyc), 32'd1);
    chk("fl_adr",   ibus.adr, 32'h704);
    ack_step(32'h7080_0004);
    chk("fl_en",  32'(wb_en), 32'd1);
    chk("fl_rdt", 32'(wb_rdt), 32'h1C20_0001);
    step();
    ack_step(32'h0);

    // Randomized request stream against the memory model
    auto_ack = 1'b1;
    last = 32'h1000;
    for (int n = 0; n < 200; n++) begin
      for (int g = 0; g < 50 && busy; g++) step();
      r = int'($urandom_range(0, 9));
      if (r < 6)       rpc = last + 32'd4;
      else if (r < 8)  rpc = 32'($urandom_range(0, 63)) << 2;
      else if (r == 8) rpc = last;
      else             rpc = last + 32'($urandom_range(1, 3));
      exp_mis = (rpc[1:0] != 2'b00);
      if (!exp_mis) last = rpc;
      fl = ($urandom_range(0, 9) == 0);
      flush = fl;
      req(rpc);
      flush = 1'b0;
      got = wb_en | fault | misal;
      for (int g = 0; g < 40 && !got; g++) begin
        step();
        got = wb_en | fault | misal;
      end
      chk("rsp_seen", 32'(got), 32'd1);
      if (got) begin
        chk("rsp_mis",   32'(misal), 32'(exp_mis));
        chk("rsp_fault", 32'(fault), 32'd0);
        chk("rsp_en",    32'(wb_en), 32'(!exp_mis));
        if (!exp_mis) begin
          ew = mem(rpc);
          chk("rsp_data", 32'(wb_rdt), 32'(ew[31:2]));
        end
      end
      step();
      chk("rsp_once", 32'({wb_en, fault, misal}), 32'd0);
      r = int'($urandom_range(0, 3));
      for (int k = 0; k < r; k++) begin
        flush = ($urandom_range(0, 15) == 0);
        step();
        flush = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
